axi_lite_mem_responder: RTL
===========================

Name: axi_lite_mem_responder

Overview:
- AXI-Lite slave memory model that answers the AXI-Lite master traffic issued by the CGRA test state machines.
- Stream input data is read from it, and CGRA output results are written back to it.
- Sits on the far side of the AXI-Lite link, in place of system memory, for standalone CGRA test benches and FPGA bring-up.
- Single outstanding read and single outstanding write, processed independently. Configurable read latency. Range-checked decode with SLVERR.

Parameters:
- ADDR_WIDTH, 32, AXI-Lite address width.
- DATA_WIDTH, 64, data width; STRB width = DATA_WIDTH/8.
- MEM_WORDS, 256, number of DATA_WIDTH-bit words of storage.
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- READ_LATENCY, 2, extra wait cycles between AR handshake and r_valid (0..15).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- aw_addr_i  in  ADDR_WIDTH  write address
- aw_valid_i  in  1  / aw_ready_o  out  1  AW handshake
- w_data_i  in  DATA_WIDTH  write data
- w_strb_i  in  DATA_WIDTH/8  byte strobes
- w_valid_i  in  1  / w_ready_o  out  1  W handshake
- b_resp_o  out  2  write response (00 OKAY, 10 SLVERR)
- b_valid_o  out  1  / b_ready_i  in  1  B handshake
- ar_addr_i  in  ADDR_WIDTH  read address
- ar_valid_i  in  1  / ar_ready_o  out  1  AR handshake
- r_data_o  out  DATA_WIDTH  read data
- r_resp_o  out  2  read response
- r_valid_o  out  1  / r_ready_i  in  1  R handshake
- wr_count_o  out  16  completed B handshakes, wraps at 2^16
- rd_count_o  out  16  completed R handshakes, wraps at 2^16

Behaviour:
- Reset (async, rst_ni=0): all readies, b_valid_o and r_valid_o are 0; b_resp_o, r_resp_o, r_data_o are 0; counters are 0; FSMs go to IDLE; latched flags are cleared.
  - rst_done_q resets to 0 and sets to 1 on the first clock edge after release. All readies are gated by rst_done_q.
  - Memory array is not reset; contents survive reset. Never-written words read as undefined.
- Decode: in range iff addr >= BASE_ADDR and idx < MEM_WORDS, where idx = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8). The low address bits are ignored, so unaligned addresses truncate to the word.
- Write FSM, states W_IDLE and W_RESP:
  - W_IDLE: aw_ready_o = !aw_latched; w_ready_o = !w_latched.
  - AW and W are accepted independently, in either order or in the same cycle. Each is captured on its handshake edge.
  - On the edge where both are latched (or both handshake together), the write commits: each byte with strb=1 updates mem[idx]. Then go to W_RESP.
  - Out-of-range address: no memory change, resp=SLVERR.
  - W_RESP: b_valid_o=1, readies 0, b_resp_o stable. On b_valid&&b_ready: clear latches, increment wr_count_o, return to W_IDLE.
  - Minimum latency: AW+W handshake at edge N gives b_valid_o high in cycle N+1.
- Read FSM, states R_IDLE, R_WAIT, R_RESP:
  - R_IDLE: ar_ready_o=1. On handshake, capture the address and load cnt=READ_LATENCY. Go to R_WAIT, or straight to R_RESP if READ_LATENCY=0.
  - R_WAIT: decrement cnt each cycle; when cnt==1 go to R_RESP.
  - On the edge entering R_RESP, r_data_o/r_resp_o are registered from the memory contents at that edge. Out-of-range gives data 0 and SLVERR.
  - r_valid_o is high in cycle N+1+READ_LATENCY after an AR handshake at edge N.
  - R_RESP: data and resp are held stable until r_ready_i. On handshake, increment rd_count_o and go to R_IDLE. ar_ready_o=0 outside R_IDLE.
- Simultaneous write commit and read sample to the same word on the same edge: read returns the old data.
- Backpressure: b_ready_i/r_ready_i held low for any number of cycles. The response is held and no new transaction is accepted on that channel.
- Read and write channels never stall each other.
- Reset mid-transaction: pending transactions are discarded with no response. A write commits only if its commit edge preceded reset assertion.

Test Plan:
- AW+W same cycle: addr 0x8000_0010, data 0x1122334455667788, strb 0xFF. Then AR same addr, READ_LATENCY=2 -> b_valid 1 cycle after, OKAY; r_valid exactly 3 cycles after AR handshake with the same data, OKAY; wr_count=1, rd_count=1.
- W presented 3 cycles before AW, strb 0x0F over a word preloaded with 0xAAAA...AAAA -> single B after AW; readback 0xAAAAAAAA55667788-style merge (only bytes 0-3 updated).
- Out-of-range: write 0x8000_0800 (idx 256) and read 0x7FFF_FFF8 -> both SLVERR; r_data 0; no memory word changed (spot-check idx 0 and 255).
- Backpressure: hold r_ready_i=0 for 10 cycles and b_ready_i=0 for 7 cycles -> valid and data stable throughout; ar_ready/aw_ready low until handshake; counters increment once each.
- Same-edge collision: write commit and read sample on the same edge to idx 5 (old 0x0, new 0xFFFF) -> read returns 0x0; next read returns 0xFFFF.
- Reset asserted in R_WAIT and with W latched but AW pending -> all valids/readies 0 immediately; after release no B/R emitted; readies rise one cycle after release; counters 0; prior memory contents intact.

Source files
------------

// File: rtl/axi_lite_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : axi_lite_mem_responder                                       |
// | Description : AXI-Lite slave memory model standing in for system memory.   |
// |               One outstanding write and one outstanding read, handled by   |
// |               independent FSMs. Configurable read latency, range-checked   |
// |               decode answering SLVERR outside the window.                  |
// | Ports       : clk_i / rst_ni      clock, asynchronous active-low reset     |
// |               aw_* / w_* / b_*    write address, data, response channels   |
// |               ar_* / r_*          read address and data channels           |
// |               wr_count_o          completed B handshakes (wraps at 2^16)   |
// |               rd_count_o          completed R handshakes (wraps at 2^16)   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module axi_lite_mem_responder #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 64,
    parameter int                    MEM_WORDS    = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h8000_0000,
    parameter int                    READ_LATENCY = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [ADDR_WIDTH-1:0]   aw_addr_i,
    input  logic                    aw_valid_i,
    output logic                    aw_ready_o,
    input  logic [DATA_WIDTH-1:0]   w_data_i,
    input  logic [DATA_WIDTH/8-1:0] w_strb_i,
    input  logic                    w_valid_i,
    output logic                    w_ready_o,
    output logic [1:0]              b_resp_o,
    output logic                    b_valid_o,
    input  logic                    b_ready_i,
    input  logic [ADDR_WIDTH-1:0]   ar_addr_i,
    input  logic                    ar_valid_i,
    output logic                    ar_ready_o,
    output logic [DATA_WIDTH-1:0]   r_data_o,
    output logic [1:0]              r_resp_o,
    output logic                    r_valid_o,
    input  logic                    r_ready_i,
    output logic [15:0]             wr_count_o,
    output logic [15:0]             rd_count_o
);

    localparam int         c_strb_width = DATA_WIDTH / 8;
    localparam int         c_byte_shift = $clog2(c_strb_width);
    localparam int         c_idx_width  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [1:0] c_resp_okay  = 2'b00;
    localparam logic [1:0] c_resp_slverr = 2'b10;

    typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} wstate_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_RESP = 2'd2} rstate_t;

    // Address below the base wraps to a huge offset in the subtraction, so the
    // explicit >= test is what rejects it.
    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] off;
        off = (addr - BASE_ADDR) >> c_byte_shift;
        return (addr >= BASE_ADDR) && (off < ADDR_WIDTH'(MEM_WORDS));
    endfunction

    function automatic logic [c_idx_width-1:0] addr_to_idx(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] off;
        off = (addr - BASE_ADDR) >> c_byte_shift;
        return off[c_idx_width-1:0];
    endfunction

    // Storage is deliberately outside the reset domain so contents survive reset.
    logic [DATA_WIDTH-1:0]   r_mem [MEM_WORDS];

    logic                    r_rst_done;

    // ---------------- write channel ----------------
    wstate_t                 r_wstate, w_wstate_nxt;
    logic                    r_aw_latched, r_w_latched;
    logic [ADDR_WIDTH-1:0]   r_aw_addr;
    logic [DATA_WIDTH-1:0]   r_w_data;
    logic [c_strb_width-1:0] r_w_strb;
    logic [1:0]              r_b_resp;
    logic [15:0]             r_wr_count;

    logic                    w_aw_hs, w_w_hs, w_b_hs, w_commit, w_wr_in_range;
    logic [ADDR_WIDTH-1:0]   w_wr_addr;
    logic [DATA_WIDTH-1:0]   w_wr_data;
    logic [c_strb_width-1:0] w_wr_strb;
    logic [c_idx_width-1:0]  w_wr_idx;

    assign aw_ready_o = r_rst_done && (r_wstate == W_IDLE) && !r_aw_latched;
    assign w_ready_o  = r_rst_done && (r_wstate == W_IDLE) && !r_w_latched;
    assign w_aw_hs    = aw_valid_i && aw_ready_o;
    assign w_w_hs     = w_valid_i && w_ready_o;
    assign b_valid_o  = (r_wstate == W_RESP);
    assign w_b_hs     = b_valid_o && b_ready_i;
    assign b_resp_o   = r_b_resp;
    assign wr_count_o = r_wr_count;

    // A half arriving on the commit edge is used straight from the bus.
    assign w_wr_addr     = w_aw_hs ? aw_addr_i : r_aw_addr;
    assign w_wr_data     = w_w_hs ? w_data_i : r_w_data;
    assign w_wr_strb     = w_w_hs ? w_strb_i : r_w_strb;
    assign w_commit      = (r_wstate == W_IDLE) && (r_aw_latched || w_aw_hs) && (r_w_latched || w_w_hs);
    assign w_wr_in_range = addr_in_range(w_wr_addr);
    assign w_wr_idx      = addr_to_idx(w_wr_addr);

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE:  if (w_commit) w_wstate_nxt = W_RESP;
            W_RESP:  if (b_ready_i) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rst_done   <= 1'b0;
            r_wstate     <= W_IDLE;
            r_aw_latched <= 1'b0;
            r_w_latched  <= 1'b0;
            r_aw_addr    <= '0;
            r_w_data     <= '0;
            r_w_strb     <= '0;
            r_b_resp     <= c_resp_okay;
            r_wr_count   <= '0;
        end else begin
            r_rst_done <= 1'b1;
            r_wstate   <= w_wstate_nxt;
            if (w_aw_hs) begin
                r_aw_latched <= 1'b1;
                r_aw_addr    <= aw_addr_i;
            end
            if (w_w_hs) begin
                r_w_latched <= 1'b1;
                r_w_data    <= w_data_i;
                r_w_strb    <= w_strb_i;
            end
            if (w_commit)
                r_b_resp <= w_wr_in_range ? c_resp_okay : c_resp_slverr;
            if (w_b_hs) begin
                r_aw_latched <= 1'b0;
                r_w_latched  <= 1'b0;
                r_wr_count   <= r_wr_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_commit && w_wr_in_range) begin
            for (int b = 0; b < c_strb_width; b++) begin
                if (w_wr_strb[b])
                    r_mem[w_wr_idx][b*8 +: 8] <= w_wr_data[b*8 +: 8];
            end
        end
    end

    // ---------------- read channel ----------------
    rstate_t                 r_rstate, w_rstate_nxt;
    logic [ADDR_WIDTH-1:0]   r_ar_addr;
    logic [3:0]              r_rd_cnt;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [1:0]              r_rresp;
    logic [15:0]             r_rd_count;

    logic                    w_ar_hs, w_r_hs, w_rd_sample, w_rd_in_range;
    logic [ADDR_WIDTH-1:0]   w_rd_addr;
    logic [c_idx_width-1:0]  w_rd_idx;

    assign ar_ready_o = r_rst_done && (r_rstate == R_IDLE);
    assign w_ar_hs    = ar_valid_i && ar_ready_o;
    assign r_valid_o  = (r_rstate == R_RESP);
    assign w_r_hs     = r_valid_o && r_ready_i;
    assign r_data_o   = r_rdata;
    assign r_resp_o   = r_rresp;
    assign rd_count_o = r_rd_count;

    // With zero latency the sample happens on the AR handshake edge itself.
    assign w_rd_addr     = (r_rstate == R_IDLE) ? ar_addr_i : r_ar_addr;
    assign w_rd_sample   = (w_ar_hs && (READ_LATENCY == 0)) || ((r_rstate == R_WAIT) && (r_rd_cnt == 4'd1));
    assign w_rd_in_range = addr_in_range(w_rd_addr);
    assign w_rd_idx      = addr_to_idx(w_rd_addr);

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rstate_nxt = (READ_LATENCY == 0) ? R_RESP : R_WAIT;
            R_WAIT:  if (r_rd_cnt == 4'd1) w_rstate_nxt = R_RESP;
            R_RESP:  if (r_ready_i) w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // The memory is read with the pre-edge contents, so a write committing on
    // the same edge is not visible to this sample.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rstate   <= R_IDLE;
            r_ar_addr  <= '0;
            r_rd_cnt   <= '0;
            r_rdata    <= '0;
            r_rresp    <= c_resp_okay;
            r_rd_count <= '0;
        end else begin
            r_rstate <= w_rstate_nxt;
            if (w_ar_hs) begin
                r_ar_addr <= ar_addr_i;
                r_rd_cnt  <= 4'(READ_LATENCY);
            end else if ((r_rstate == R_WAIT) && (r_rd_cnt != 4'd1)) begin
                r_rd_cnt <= r_rd_cnt - 4'd1;
            end
            if (w_rd_sample) begin
                r_rdata <= w_rd_in_range ? r_mem[w_rd_idx] : '0;
                r_rresp <= w_rd_in_range ? c_resp_okay : c_resp_slverr;
            end
            if (w_r_hs)
                r_rd_count <= r_rd_count + 16'd1;
        end
    end

endmodule
`default_nettype wire
